// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between NREQ packet sources and one FIFO write port.
//   master modport: the arbiter (consumes requests, drives FIFO writes)
//   slave  modport: the requesters / FIFO model (drive requests, full flag)
// Signals:
//   req_valid[NREQ]        per-requester data valid
//   req_data[NREQ*DSIZE]   requester i at [i*DSIZE +: DSIZE]
//   req_last[NREQ]         last beat of packet, qualified by req_valid
//   req_ready[NREQ]        per-requester accept strobe
//   w_full                 FIFO full flag
//   w_en / w_data          FIFO write enable and data
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  w_full;
  logic                  w_en;
  logic [DSIZE-1:0]      w_data;

  modport master (
    input  req_valid, req_data, req_last, w_full,
    output req_ready, w_en, w_data
  );

  modport slave (
    output req_valid, req_data, req_last, w_full,
    input  req_ready, w_en, w_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter feeding a single FIFO write port.
// A grant is held until the owner's last beat or MAX_BURST beats, then the
// arbiter spends at least one cycle in IDLE before granting again. The
// search for the next owner starts just above the previous owner.
// Ports:
//   w_clk     write-domain clock
//   w_rst_n   asynchronous active-low reset (deassertion synchronised outside)
//   bus       fifo_wr_arbiter_if.master (requests in, FIFO writes out);
//             interface DSIZE/NREQ must match this module's parameters
//   grant_id  index of the current (or most recent) grant holder
//   busy      high while a grant is active
module fifo_wr_arbiter #(
  parameter  int DSIZE     = 8,
  parameter  int NREQ      = 4,
  parameter  int MAX_BURST = 4,
  localparam int GW        = $clog2(NREQ)
) (
  input  logic                    w_clk,
  input  logic                    w_rst_n,
  fifo_wr_arbiter_if.master       bus,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [4:0]    MAX_BURST_C = 5'(MAX_BURST);
  localparam logic [GW-1:0] LAST_PTR_RST = GW'(NREQ - 1);

  state_e          state_q,    state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   last_ptr_q, last_ptr_d;
  logic [4:0]      cnt_q,      cnt_d;

  logic [GW-1:0]   cand_s;
  logic [GW-1:0]   sel_idx_s;
  logic            sel_found_s;
  logic            gnt_valid_s;
  logic            gnt_last_s;
  logic [NREQ-1:0] ready_s;
  logic [DSIZE-1:0] w_data_s;
  logic            beat_s;
  logic [4:0]      cnt_inc_s;

  // Round-robin pick: first valid requester at or above last_ptr+1, wrapping.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {GW{1'b0}};
    cand_s      = {GW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = GW'((int'(last_ptr_q) + i) % NREQ);
      if (!sel_found_s && bus.req_valid[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Route the grant holder's request signals and build the ready strobes.
  // w_full gates every ready bit so a stalled cycle accepts nothing.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_last_s  = 1'b0;
    w_data_s    = {DSIZE{1'b0}};
    ready_s     = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        gnt_valid_s = bus.req_valid[i];
        gnt_last_s  = bus.req_last[i];
        w_data_s    = bus.req_data[i*DSIZE +: DSIZE];
        ready_s[i]  = (state_q == ST_GRANT) && !bus.w_full;
      end else begin
        ready_s[i]  = 1'b0;
      end
    end
  end

  assign beat_s    = (state_q == ST_GRANT) && !bus.w_full && gnt_valid_s;
  assign cnt_inc_s = cnt_q + 5'd1;

  // Next-state logic: grant from IDLE, count beats and release in GRANT.
  // A dropped valid or a full FIFO simply yields no beat, so state,
  // counter and grant_id all hold.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_d    = ST_GRANT;
          grant_id_d = sel_idx_s;
          cnt_d      = 5'd0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (beat_s) begin
          cnt_d = cnt_inc_s;
          if (gnt_last_s || (cnt_inc_s == MAX_BURST_C)) begin
            state_d    = ST_IDLE;
            last_ptr_d = grant_id_q;
          end else begin
            state_d    = ST_GRANT;
          end
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_id_d = {GW{1'b0}};
        last_ptr_d = LAST_PTR_RST;
        cnt_d      = 5'd0;
      end
    endcase
  end

  // State registers; reset leaves last_ptr at NREQ-1 so requester 0 wins first.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= ST_IDLE;
      grant_id_q <= {GW{1'b0}};
      last_ptr_q <= LAST_PTR_RST;
      cnt_q      <= 5'd0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Handshake outputs are combinational from registered state, so reset
  // kills them in the same cycle.
  assign bus.req_ready = ready_s;
  assign bus.w_en      = beat_s;
  assign bus.w_data    = w_data_s;
  assign grant_id      = grant_id_q;
  assign busy          = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed + random bench for fifo_wr_arbiter. Packet sources and a
// transaction-level arbiter model live here; the DUT is checked on every
// cycle and a few hand-computed grant/data logs pin the model.
module tb_fifo_wr_arbiter;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int MAXB  = 4;

  logic       w_clk = 1'b0;
  logic       w_rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy;

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_bad = 0;

  // packet sources
  int src_pkts [NREQ];
  int src_len  [NREQ];
  int src_rem  [NREQ];
  int src_seq  [NREQ];
  bit src_nolast [NREQ];
  bit hold_off [NREQ];
  bit full_r;
  bit rand_mode;

  // arbiter model: who owns the port, beats so far, previous owner
  bit m_busy;
  int m_owner;
  int m_beats;
  int m_lastp;

  // logs observed from the DUT
  int         glog[$];
  int         blog[$];
  logic [7:0] dlog[$];
  bit         prev_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qget_i(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  function automatic int qget_d(input logic [7:0] q[$], input int idx);
    if (idx < q.size()) return int'(q[idx]);
    return -1;
  endfunction

  function automatic logic [7:0] src_word(input int i);
    return 8'(i * 64 + (src_seq[i] % 64));
  endfunction

  function automatic bit src_valid(input int i);
    return (src_pkts[i] > 0) && !hold_off[i];
  endfunction

  function automatic bit src_last(input int i);
    return src_valid(i) && (src_rem[i] == 1) && !src_nolast[i];
  endfunction

  task automatic set_src(input int i, input int pkts, input int len, input bit nolast);
    src_pkts[i]   = pkts;
    src_len[i]    = len;
    src_rem[i]    = len;
    src_nolast[i] = nolast;
  endtask

  task automatic advance(input int i);
    src_seq[i]++;
    src_rem[i]--;
    if (src_rem[i] == 0) begin
      src_pkts[i]--;
      src_rem[i] = src_len[i];
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]             = src_valid(i);
      bus.req_last[i]              = src_last(i);
      bus.req_data[i*DSIZE +: DSIZE] = src_word(i);
    end
    bus.w_full = full_r;
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_lastp = NREQ - 1;
  endtask

  function automatic int first_from(input int lp);
    for (int k = 1; k <= NREQ; k++) begin
      if (src_valid((lp + k) % NREQ)) return (lp + k) % NREQ;
    end
    return -1;
  endfunction

  // one clock edge of the model
  task automatic model_step();
    int c;
    bit lst;
    if (!w_rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      c = first_from(m_lastp);
      if (c >= 0) begin
        m_busy  = 1'b1;
        m_owner = c;
        m_beats = 0;
      end
    end else if (!full_r && src_valid(m_owner)) begin
      lst = src_last(m_owner);
      m_beats++;
      advance(m_owner);
      if (lst || m_beats == MAXB) begin
        m_busy  = 1'b0;
        m_lastp = m_owner;
      end
    end
  endtask

  task automatic compare();
    bit         exp_wen;
    logic [3:0] exp_rdy;
    exp_wen = m_busy && !full_r && src_valid(m_owner);
    for (int i = 0; i < NREQ; i++) exp_rdy[i] = m_busy && (m_owner == i) && !full_r;
    chk("w_en", 32'(bus.w_en), 32'(exp_wen));
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    if (exp_wen) chk("w_data", 32'(bus.w_data), 32'(src_word(m_owner)));
    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_id));
      blog.push_back(0);
    end
    if (bus.w_en) begin
      dlog.push_back(bus.w_data);
      if (blog.size() > 0) blog[blog.size()-1]++;
    end
    prev_busy = busy;
  endtask

  task automatic randomize_sources();
    for (int i = 0; i < NREQ; i++) begin
      if (src_pkts[i] == 0 && $urandom_range(0, 3) == 0)
        set_src(i, 1, int'($urandom_range(1, 6)), $urandom_range(0, 4) == 0);
      hold_off[i] = ($urandom_range(0, 7) == 0);
    end
    full_r = ($urandom_range(0, 3) == 0);
  endtask

  task automatic cycle();
    @(negedge w_clk);
    compare();
    @(posedge w_clk);
    model_step();
    #1;
    if (rand_mode) randomize_sources();
    drive();
  endtask

  task automatic clear_logs();
    glog.delete();
    blog.delete();
    dlog.delete();
  endtask

  task automatic start_test();
    w_rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      set_src(i, 0, 1, 1'b0);
      src_seq[i]  = 0;
      hold_off[i] = 1'b0;
    end
    full_r = 1'b0;
    model_reset();
    drive();
    clear_logs();
    prev_busy = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_w_en", 32'(bus.w_en), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    cycle();
    #1 w_rst_n = 1'b1;
  endtask

  initial begin
    rand_mode = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.w_full    = 1'b0;
    #2;

    // single requester, 3-beat packet
    start_test();
    set_src(2, 1, 3, 1'b0);
    drive();
    repeat (8) cycle();
    chk("t1_ngrants", 32'(glog.size()), 32'd1);
    chk("t1_grant0", 32'(qget_i(glog, 0)), 32'd2);
    chk("t1_nbeats", 32'(qget_i(blog, 0)), 32'd3);
    chk("t1_d0", 32'(qget_d(dlog, 0)), 32'h80);
    chk("t1_d1", 32'(qget_d(dlog, 1)), 32'h81);
    chk("t1_d2", 32'(qget_d(dlog, 2)), 32'h82);

    // round robin with 1-beat packets, requester 0 has two
    start_test();
    set_src(0, 2, 1, 1'b0);
    set_src(1, 1, 1, 1'b0);
    set_src(2, 1, 1, 1'b0);
    set_src(3, 1, 1, 1'b0);
    drive();
    repeat (14) cycle();
    chk("t2_ngrants", 32'(glog.size()), 32'd5);
    chk("t2_g0", 32'(qget_i(glog, 0)), 32'd0);
    chk("t2_g1", 32'(qget_i(glog, 1)), 32'd1);
    chk("t2_g2", 32'(qget_i(glog, 2)), 32'd2);
    chk("t2_g3", 32'(qget_i(glog, 3)), 32'd3);
    chk("t2_g4", 32'(qget_i(glog, 4)), 32'd0);

    // burst cap: requester 1 streams 10 beats, 0 and 2 join later
    start_test();
    set_src(1, 1, 10, 1'b1);
    drive();
    cycle();
    cycle();
    set_src(0, 1, 1, 1'b0);
    set_src(2, 1, 1, 1'b0);
    drive();
    repeat (30) cycle();
    chk("t3_ngrants", 32'(glog.size()), 32'd5);
    chk("t3_g0", 32'(qget_i(glog, 0)), 32'd1);
    chk("t3_g1", 32'(qget_i(glog, 1)), 32'd2);
    chk("t3_g2", 32'(qget_i(glog, 2)), 32'd0);
    chk("t3_g3", 32'(qget_i(glog, 3)), 32'd1);
    chk("t3_g4", 32'(qget_i(glog, 4)), 32'd1);
    chk("t3_b0", 32'(qget_i(blog, 0)), 32'd4);
    chk("t3_b3", 32'(qget_i(blog, 3)), 32'd4);
    chk("t3_b4", 32'(qget_i(blog, 4)), 32'd2);

    // backpressure: 5 full cycles after 3 beats of an 8-beat packet
    start_test();
    set_src(0, 1, 8, 1'b0);
    drive();
    for (int k = 0; k < 20 && !(m_busy && m_beats == 3); k++) cycle();
    chk("t4_reach_beat3", 32'(m_busy && m_beats == 3), 32'd1);
    full_r = 1'b1;
    drive();
    repeat (5) begin
      #3;
      chk("t4_stall_w_en", 32'(bus.w_en), 32'd0);
      chk("t4_stall_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_stall_gid", 32'(grant_id), 32'd0);
      cycle();
    end
    full_r = 1'b0;
    drive();
    repeat (15) cycle();
    chk("t4_ndata", 32'(dlog.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("t4_data", 32'(qget_d(dlog, k)), 32'(k));
    chk("t4_b0", 32'(qget_i(blog, 0)), 32'd4);
    chk("t4_b1", 32'(qget_i(blog, 1)), 32'd4);

    // reset during beat 2 of requester 3
    start_test();
    set_src(3, 1, 6, 1'b0);
    drive();
    for (int k = 0; k < 20 && !(m_busy && m_owner == 3 && m_beats == 1); k++) cycle();
    chk("t5_reach_beat2", 32'(m_busy && m_owner == 3 && m_beats == 1), 32'd1);
    #1;
    chk("t5_beat2_w_en", 32'(bus.w_en), 32'd1);
    w_rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_w_en", 32'(bus.w_en), 32'd0);
    chk("t5_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    cycle();
    #1 w_rst_n = 1'b1;
    set_src(0, 1, 1, 1'b0);
    set_src(1, 1, 1, 1'b0);
    set_src(2, 1, 1, 1'b0);
    drive();
    clear_logs();
    prev_busy = 1'b0;
    repeat (6) cycle();
    chk("t5_first_grant", 32'(qget_i(glog, 0)), 32'd0);

    // random traffic with random full and valid drops
    start_test();
    rand_mode = 1'b1;
    repeat (400) cycle();
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
